// File: rtl/if_id_branch_stage_pkg.sv
// Shared pipeline definitions: datapath width, NOP encoding, branch opcodes,
// the IF/ID register payload and the register-dependence helper.
package if_id_branch_stage_pkg;

    localparam int unsigned DW  = 32;
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [5:0]  BEQ = 6'h04;
    localparam logic [5:0]  BNE = 6'h05;

    typedef struct packed {
        logic          valid;
        logic [DW-1:0] pc4;
        logic [31:0]   instr;
    } ifid_t;

    // $0 is hardwired to zero, so a write to it never creates a dependence.
    function automatic logic reg_hit(input logic [4:0] rd,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt);
        return (rd != 5'd0) && ((rd == rs) || (rd == rt));
    endfunction

endpackage

// File: rtl/if_id_branch_stage_if.sv
// Pipeline-side bundle of the IF/ID + ID branch stage; master drives fetch,
// regfile, control and hazard inputs, slave is the stage itself.
interface if_id_branch_stage_if;
    import if_id_branch_stage_pkg::*;

    logic [DW-1:0] IF_PC4;
    logic [31:0]   IF_Instr;
    logic [DW-1:0] ID_RD1;
    logic [DW-1:0] ID_RD2;
    logic [DW-1:0] EX_ALUResult;
    logic          forward3;
    logic          forward4;
    logic          Branch;
    logic          BranchNE;
    logic          EX_MemRead;
    logic          EX_RegWrite;
    logic [4:0]    EXReg_Rd;
    logic          MEM_RegWrite;
    logic [4:0]    MEMReg_Rd;

    logic [DW-1:0] ID_PC4;
    logic [31:0]   ID_Instr;
    logic          ID_Valid;
    logic [4:0]    IFReg_Rs;
    logic [4:0]    IFReg_Rt;
    logic          PCWrite;
    logic          IFIDWrite;
    logic          IDEX_Bubble;
    logic          PCSrc;
    logic [DW-1:0] BranchTarget;

    modport master (
        output IF_PC4, IF_Instr, ID_RD1, ID_RD2, EX_ALUResult, forward3, forward4,
               Branch, BranchNE, EX_MemRead, EX_RegWrite, EXReg_Rd,
               MEM_RegWrite, MEMReg_Rd,
        input  ID_PC4, ID_Instr, ID_Valid, IFReg_Rs, IFReg_Rt, PCWrite,
               IFIDWrite, IDEX_Bubble, PCSrc, BranchTarget
    );

    modport slave (
        input  IF_PC4, IF_Instr, ID_RD1, ID_RD2, EX_ALUResult, forward3, forward4,
               Branch, BranchNE, EX_MemRead, EX_RegWrite, EXReg_Rd,
               MEM_RegWrite, MEMReg_Rd,
        output ID_PC4, ID_Instr, ID_Valid, IFReg_Rs, IFReg_Rt, PCWrite,
               IFIDWrite, IDEX_Bubble, PCSrc, BranchTarget
    );

endinterface

// File: rtl/if_id_branch_stage_branch_stall_fsm.sv
// Branch stall sequencer: turns load-use / MEM-stage hazard flags into a
// multi-cycle stall, re-evaluating the branch only after returning to RUN.
module if_id_branch_stage_branch_stall_fsm #(
    parameter int unsigned LOAD_STALL = 2,
    parameter int unsigned MEM_STALL  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hz_load,
    input  logic hz_mem,
    output logic stall_c
);

    localparam int unsigned MAX_STALL = (LOAD_STALL > MEM_STALL) ? LOAD_STALL : MEM_STALL;
    localparam int unsigned CNT_W     = $clog2(MAX_STALL + 1);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = (state_q == STALL) | (hz_load | hz_mem);
        case (state_q)
            RUN: begin
                // A one-cycle stall needs no STALL state: the hazard itself holds for that cycle.
                if (hz_load) begin
                    if (LOAD_STALL > 1) begin
                        state_d = STALL;
                        cnt_d   = CNT_W'(LOAD_STALL - 1);
                    end
                end else if (hz_mem) begin
                    if (MEM_STALL > 1) begin
                        state_d = STALL;
                        cnt_d   = CNT_W'(MEM_STALL - 1);
                    end
                end
            end
            STALL: begin
                stall_c = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
        if (state_q == STALL) begin
            stall_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/if_id_branch_stage.sv
// IF/ID pipeline register with ID-stage beq/bne resolution, branch hazard
// stall control and taken-branch flush of the delay-slot fetch.
module if_id_branch_stage
    import if_id_branch_stage_pkg::*;
#(
    parameter int unsigned LOAD_STALL = 2,
    parameter int unsigned MEM_STALL  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    if_id_branch_stage_if.slave  bus
);

    ifid_t          ifid_q, ifid_d;
    logic [4:0]     rs, rt;
    logic           br_active, hz_load, hz_mem, stall_c, eq, pcsrc_c;
    logic [DW-1:0]  op_a, op_b, imm_sext;

    assign rs = ifid_q.instr[25:21];
    assign rt = ifid_q.instr[20:16];

    // Hazards only matter for a real branch sitting in ID; the FSM masks them while stalled.
    assign br_active = ifid_q.valid & bus.Branch;
    assign hz_load   = br_active & bus.EX_MemRead & bus.EX_RegWrite & reg_hit(bus.EXReg_Rd, rs, rt);
    assign hz_mem    = br_active & ~hz_load & bus.MEM_RegWrite & reg_hit(bus.MEMReg_Rd, rs, rt);

    if_id_branch_stage_branch_stall_fsm #(
        .LOAD_STALL (LOAD_STALL),
        .MEM_STALL  (MEM_STALL)
    ) u_branch_stall_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .hz_load (hz_load),
        .hz_mem  (hz_mem),
        .stall_c (stall_c)
    );

    assign op_a     = bus.forward3 ? bus.EX_ALUResult : bus.ID_RD1;
    assign op_b     = bus.forward4 ? bus.EX_ALUResult : bus.ID_RD2;
    assign eq       = (op_a == op_b);
    assign pcsrc_c  = br_active & ~stall_c & (eq ^ bus.BranchNE);
    assign imm_sext = {{(DW-16){ifid_q.instr[15]}}, ifid_q.instr[15:0]};

    assign bus.ID_PC4       = ifid_q.pc4;
    assign bus.ID_Instr     = ifid_q.instr;
    assign bus.ID_Valid     = ifid_q.valid;
    assign bus.IFReg_Rs     = rs;
    assign bus.IFReg_Rt     = rt;
    assign bus.PCWrite      = ~stall_c;
    assign bus.IFIDWrite    = ~stall_c;
    assign bus.IDEX_Bubble  = stall_c;
    assign bus.PCSrc        = pcsrc_c;
    assign bus.BranchTarget = ifid_q.pc4 + (imm_sext << 2);

    // Stall holds, a taken branch squashes the delay-slot fetch, otherwise advance.
    always_comb begin
        ifid_d = ifid_q;
        if (!stall_c) begin
            if (pcsrc_c) begin
                ifid_d = '{valid: 1'b0, pc4: '0, instr: NOP};
            end else begin
                ifid_d = '{valid: 1'b1, pc4: bus.IF_PC4, instr: bus.IF_Instr};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q <= '{valid: 1'b0, pc4: '0, instr: NOP};
        end else begin
            ifid_q <= ifid_d;
        end
    end

endmodule

// File: tb/tb_if_id_branch_stage.sv
// Directed bench for the IF/ID + ID branch stage: reset, taken/not-taken
// branches, forwarding, load-use and MEM stalls, reset mid-stall.
module tb_if_id_branch_stage;
    import if_id_branch_stage_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    if_id_branch_stage_if bus();

    if_id_branch_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic clear_ctl();
        bus.Branch       = 1'b0;
        bus.BranchNE     = 1'b0;
        bus.forward3     = 1'b0;
        bus.forward4     = 1'b0;
        bus.EX_MemRead   = 1'b0;
        bus.EX_RegWrite  = 1'b0;
        bus.EXReg_Rd     = 5'd0;
        bus.MEM_RegWrite = 1'b0;
        bus.MEMReg_Rd    = 5'd0;
        bus.ID_RD1       = '0;
        bus.ID_RD2       = '0;
        bus.EX_ALUResult = '0;
    endtask

    // Place an instruction into IF and clock it into ID with no control active.
    task automatic load_id(input logic [31:0] instr, input logic [31:0] pc4);
        clear_ctl();
        bus.IF_Instr = instr;
        bus.IF_PC4   = pc4;
        tick();
        bus.IF_Instr = 32'hDEAD_0000 | pc4;
        bus.IF_PC4   = pc4 + 32'd4;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        clear_ctl();
        bus.IF_Instr = 32'h1111_1111;
        bus.IF_PC4   = 32'h0000_0040;

        #3;
        check("rst_valid",  64'(bus.ID_Valid),    64'd0);
        check("rst_instr",  64'(bus.ID_Instr),    64'(NOP));
        check("rst_pc4",    64'(bus.ID_PC4),      64'd0);
        check("rst_pcw",    64'(bus.PCWrite),     64'd1);
        check("rst_ifidw",  64'(bus.IFIDWrite),   64'd1);
        check("rst_bubble", 64'(bus.IDEX_Bubble), 64'd0);
        check("rst_pcsrc",  64'(bus.PCSrc),       64'd0);
        tick();
        check("rst_hold", 64'(bus.ID_Instr), 64'(NOP));
        rst_n = 1'b1;

        // beq $1,$2 taken with negative offset
        load_id(mk(BEQ, 5'd1, 5'd2, 16'hFFFF), 32'h0000_0100);
        check("beq_rs", 64'(bus.IFReg_Rs), 64'd1);
        check("beq_rt", 64'(bus.IFReg_Rt), 64'd2);
        bus.Branch = 1'b1;
        bus.ID_RD1 = 32'd5;
        bus.ID_RD2 = 32'd5;
        #1;
        check("beq_pcsrc",  64'(bus.PCSrc),        64'd1);
        check("beq_target", 64'(bus.BranchTarget), 64'h0FC);
        check("beq_pcw",    64'(bus.PCWrite),      64'd1);
        tick();
        check("flush_instr", 64'(bus.ID_Instr), 64'(NOP));
        check("flush_valid", 64'(bus.ID_Valid), 64'd0);
        check("flush_nopc",  64'(bus.PCSrc),    64'd0);

        // lw $3 in EX, beq $3,$0 in ID: two stall cycles then resolve
        load_id(mk(BEQ, 5'd3, 5'd0, 16'h0004), 32'h0000_0200);
        bus.Branch      = 1'b1;
        bus.EX_MemRead  = 1'b1;
        bus.EX_RegWrite = 1'b1;
        bus.EXReg_Rd    = 5'd3;
        bus.ID_RD1      = 32'd9;
        #1;
        check("ld_s1_pcw",    64'(bus.PCWrite),     64'd0);
        check("ld_s1_ifidw",  64'(bus.IFIDWrite),   64'd0);
        check("ld_s1_bubble", 64'(bus.IDEX_Bubble), 64'd1);
        check("ld_s1_pcsrc",  64'(bus.PCSrc),       64'd0);
        tick();
        bus.EX_MemRead   = 1'b0;
        bus.EX_RegWrite  = 1'b0;
        bus.EXReg_Rd     = 5'd0;
        bus.MEM_RegWrite = 1'b1;
        bus.MEMReg_Rd    = 5'd3;
        bus.ID_RD1       = 32'd0;
        #1;
        check("ld_s2_pcw",    64'(bus.PCWrite),     64'd0);
        check("ld_s2_bubble", 64'(bus.IDEX_Bubble), 64'd1);
        check("ld_s2_pcsrc",  64'(bus.PCSrc),       64'd0);
        check("ld_s2_hold",   64'(bus.ID_Instr),    64'(mk(BEQ, 5'd3, 5'd0, 16'h0004)));
        tick();
        bus.MEM_RegWrite = 1'b0;
        bus.MEMReg_Rd    = 5'd0;
        #1;
        check("ld_s3_pcw",    64'(bus.PCWrite),      64'd1);
        check("ld_s3_pcsrc",  64'(bus.PCSrc),        64'd1);
        check("ld_s3_target", 64'(bus.BranchTarget), 64'h210);
        check("ld_s3_pc4",    64'(bus.ID_PC4),       64'h200);
        tick();
        check("ld_flush", 64'(bus.ID_Valid), 64'd0);

        // bne $4,$5 with Rs forwarded from EX
        load_id(mk(BNE, 5'd4, 5'd5, 16'h0002), 32'h0000_0300);
        bus.Branch       = 1'b1;
        bus.BranchNE     = 1'b1;
        bus.EX_RegWrite  = 1'b1;
        bus.EXReg_Rd     = 5'd4;
        bus.forward3     = 1'b1;
        bus.EX_ALUResult = 32'd7;
        bus.ID_RD1       = 32'd0;
        bus.ID_RD2       = 32'd7;
        #1;
        check("bne_eq_pcw",   64'(bus.PCWrite), 64'd1);
        check("bne_eq_pcsrc", 64'(bus.PCSrc),   64'd0);
        bus.ID_RD2 = 32'd8;
        #1;
        check("bne_ne_pcsrc",  64'(bus.PCSrc),        64'd1);
        check("bne_ne_target", 64'(bus.BranchTarget), 64'h308);
        tick();

        // MEM-stage dependence: one stall cycle, then taken; target wraps
        load_id(mk(BEQ, 5'd6, 5'd6, 16'h8000), 32'h0000_0400);
        bus.Branch       = 1'b1;
        bus.MEM_RegWrite = 1'b1;
        bus.MEMReg_Rd    = 5'd6;
        bus.ID_RD1       = 32'd1;
        bus.ID_RD2       = 32'd1;
        #1;
        check("mem_s1_pcw",    64'(bus.PCWrite),     64'd0);
        check("mem_s1_bubble", 64'(bus.IDEX_Bubble), 64'd1);
        check("mem_s1_pcsrc",  64'(bus.PCSrc),       64'd0);
        tick();
        bus.MEM_RegWrite = 1'b0;
        bus.MEMReg_Rd    = 5'd0;
        #1;
        check("mem_s2_pcw",    64'(bus.PCWrite),      64'd1);
        check("mem_s2_pcsrc",  64'(bus.PCSrc),        64'd1);
        check("mem_s2_target", 64'(bus.BranchTarget), 64'hFFFE_0400);
        tick();

        // Writes to $0 never stall
        load_id(mk(BEQ, 5'd0, 5'd0, 16'h0001), 32'h0000_0480);
        bus.Branch       = 1'b1;
        bus.MEM_RegWrite = 1'b1;
        bus.MEMReg_Rd    = 5'd0;
        #1;
        check("r0_pcw",   64'(bus.PCWrite), 64'd1);
        check("r0_pcsrc", 64'(bus.PCSrc),   64'd1);
        tick();

        // Non-branch with load-use on Rs: no stall, IF/ID keeps advancing
        load_id({6'h00, 5'd3, 5'd4, 5'd5, 11'h020}, 32'h0000_0500);
        bus.EX_MemRead  = 1'b1;
        bus.EX_RegWrite = 1'b1;
        bus.EXReg_Rd    = 5'd3;
        bus.IF_Instr    = 32'h0BAD_0001;
        bus.IF_PC4      = 32'h0000_0504;
        #1;
        check("nb_pcw",    64'(bus.PCWrite),     64'd1);
        check("nb_bubble", 64'(bus.IDEX_Bubble), 64'd0);
        check("nb_pcsrc",  64'(bus.PCSrc),       64'd0);
        tick();
        check("nb_adv1", 64'(bus.ID_Instr), 64'h0BAD_0001);
        bus.IF_Instr = 32'h0BAD_0002;
        bus.IF_PC4   = 32'h0000_0508;
        tick();
        check("nb_adv2",  64'(bus.ID_Instr), 64'h0BAD_0002);
        check("nb_pc4",   64'(bus.ID_PC4),   64'h508);
        check("nb_valid", 64'(bus.ID_Valid), 64'd1);

        // Reset while in STALL with cnt=1
        load_id(mk(BEQ, 5'd3, 5'd0, 16'h0004), 32'h0000_0600);
        bus.Branch      = 1'b1;
        bus.EX_MemRead  = 1'b1;
        bus.EX_RegWrite = 1'b1;
        bus.EXReg_Rd    = 5'd3;
        tick();
        clear_ctl();
        bus.Branch = 1'b1;
        #1;
        check("rs_stall_pcw", 64'(bus.PCWrite), 64'd0);
        rst_n = 1'b0;
        #1;
        check("rs_mid_valid",  64'(bus.ID_Valid),    64'd0);
        check("rs_mid_pcw",    64'(bus.PCWrite),     64'd1);
        check("rs_mid_bubble", 64'(bus.IDEX_Bubble), 64'd0);
        bus.Branch   = 1'b0;
        bus.IF_Instr = 32'h1234_5678;
        bus.IF_PC4   = 32'h0000_0604;
        tick();
        check("rs_hold_valid", 64'(bus.ID_Valid), 64'd0);
        rst_n = 1'b1;
        tick();
        check("rs_rel_instr", 64'(bus.ID_Instr), 64'h1234_5678);
        check("rs_rel_valid", 64'(bus.ID_Valid), 64'd1);
        check("rs_rel_pcw",   64'(bus.PCWrite),  64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
